// File: rtl/command_executor.sv
// rtl/command_executor.sv - executes decoded READ/WRITE frames on a req/ack memory bus and replies over a byte UART
//
// Ports:
//   clock, reset_n            system clock (rising edge), asynchronous active-low reset
//   i_command/i_address/i_data decoded frame fields, captured when i_valid pulses in IDLE
//   i_valid, i_error          frame strobe and decoder error code (nonzero = bad frame)
//   o_busy, o_overrun, o_done busy from accept to done, dropped-frame pulse, response-complete pulse
//   o_mem_*, i_mem_*          memory request held until i_mem_ack (or timeout)
//   o_tx_byte, o_tx_start     byte and start pulse to the UART transmitter
//   i_tx_done                 transmitter finished the current byte
module command_executor #(
    parameter logic [7:0] CMD_READ    = 8'h00,
    parameter logic [7:0] CMD_WRITE   = 8'h01,
    parameter logic [7:0] ACK_BYTE    = 8'hAA,
    parameter logic [7:0] NAK_BYTE    = 8'hEE,
    parameter int         MEM_TIMEOUT = 1024
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [7:0]  i_command,
    input  logic [14:0] i_address,
    input  logic [31:0] i_data,
    input  logic        i_valid,
    input  logic [1:0]  i_error,
    output logic        o_busy,
    output logic        o_overrun,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [14:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    input  logic        i_mem_ack,
    input  logic [31:0] i_mem_rdata,
    output logic [7:0]  o_tx_byte,
    output logic        o_tx_start,
    input  logic        i_tx_done,
    output logic        o_done
);

    typedef enum logic [2:0] {
        S_IDLE, S_MEM, S_TX_STAT, S_WAIT_STAT, S_TX_DATA, S_WAIT_DATA, S_FIN
    } state_t;

    localparam int             CW       = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(MEM_TIMEOUT - 1);

    state_t        state_q, state_d;
    logic [7:0]    cmd_q;
    logic [14:0]   addr_q;
    logic [31:0]   wdata_q;
    logic [31:0]   rdata_q;
    logic [7:0]    status_q;
    logic [CW-1:0] cnt_q;
    logic [1:0]    idx_q;
    logic          overrun_q;

    logic frame_ok;
    logic mem_timeout;

    assign frame_ok    = (i_error == 2'b00) && ((i_command == CMD_READ) || (i_command == CMD_WRITE));
    assign mem_timeout = (cnt_q == CNT_LAST);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:      if (i_valid) state_d = frame_ok ? S_MEM : S_TX_STAT;
            // ack takes priority over a timeout landing in the same cycle
            S_MEM:       if (i_mem_ack || mem_timeout) state_d = S_TX_STAT;
            S_TX_STAT:   state_d = S_WAIT_STAT;
            S_WAIT_STAT: if (i_tx_done)
                             state_d = ((cmd_q == CMD_READ) && (status_q == ACK_BYTE)) ? S_TX_DATA : S_FIN;
            S_TX_DATA:   state_d = S_WAIT_DATA;
            S_WAIT_DATA: if (i_tx_done) state_d = (idx_q == 2'd0) ? S_FIN : S_TX_DATA;
            S_FIN:       state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cmd_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            status_q  <= '0;
            cnt_q     <= '0;
            idx_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= i_valid && (state_q != S_IDLE);

            // counter only runs while staying in MEM, so it is zero on every MEM entry
            cnt_q <= ((state_q == S_MEM) && (state_d == S_MEM)) ? cnt_q + 1'b1 : '0;

            unique case (state_q)
                S_IDLE: if (i_valid) begin
                    cmd_q    <= i_command;
                    addr_q   <= i_address;
                    wdata_q  <= i_data;
                    status_q <= NAK_BYTE;
                end
                S_MEM: if (i_mem_ack) begin
                    status_q <= ACK_BYTE;
                    if (cmd_q == CMD_READ) rdata_q <= i_mem_rdata;
                end else if (mem_timeout) begin
                    status_q <= NAK_BYTE;
                end
                S_WAIT_STAT: if (i_tx_done) idx_q <= 2'd3;
                S_WAIT_DATA: if (i_tx_done) idx_q <= idx_q - 2'd1;
                default: ;
            endcase
        end
    end

    always_comb begin
        o_busy      = (state_q != S_IDLE);
        o_overrun   = overrun_q;
        o_mem_req   = (state_q == S_MEM);
        o_mem_we    = o_mem_req && (cmd_q == CMD_WRITE);
        o_mem_addr  = o_mem_req ? addr_q  : '0;
        o_mem_wdata = o_mem_req ? wdata_q : '0;
        o_tx_start  = (state_q == S_TX_STAT) || (state_q == S_TX_DATA);
        o_done      = (state_q == S_FIN);
        unique case (state_q)
            S_TX_STAT, S_WAIT_STAT: o_tx_byte = status_q;
            S_TX_DATA, S_WAIT_DATA: o_tx_byte = 8'(rdata_q >> {idx_q, 3'b000});
            default:                o_tx_byte = 8'h00;
        endcase
    end

endmodule
